hdmi_pattern_gen: RTL
=====================

Name: hdmi_pattern_gen

Overview:
- Parametrised successor to the fixed 640x480 video pattern generator.
- Produces HDMI/VGA raster timing (de, hs, vs) from generic porch/sync parameters with programmable sync polarity.
- Four selectable test patterns; runtime-configurable rectangle overlay.
- Sits between the pixel clock PLL and the HDMI transmitter; drives it directly for bring-up and for display-chain verification.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs
- COLOR_W, 8, bits per colour channel

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  pattern select: 0 bars, 1 checker, 2 rectangle, 3 ramp
- rect_x  in  12  rectangle left column
- rect_y  in  12  rectangle top line
- rect_w  in  12  rectangle width (pixels)
- rect_h  in  12  rectangle height (lines)
- de  out  1  data enable
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- frame_start  out  1  one-clock pulse aligned with first active pixel of a frame
- vga_r  out  COLOR_W  red
- vga_g  out  COLOR_W  green
- vga_b  out  COLOR_W  blue

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Segment order is active, front porch, sync, back porch. Active pixel coordinates are x = h_cnt, y = v_cnt.
- Raw timing: active when h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
  - hs is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs is asserted for v_cnt in the equivalent vertical window, for whole lines.
- Pipeline is two stages.
  - Stage 1 registers raw timing, x, y and the pattern selection.
  - Stage 2 registers the colour and the outputs.
  - de, hs, vs, frame_start and rgb all appear exactly 2 clocks after the counter value that produced them, and are mutually aligned.
- Output sync level: the active level of hs is HS_POL and of vs is VS_POL; the inactive level is the inverse.
- rgb is 0 whenever de is 0.
- Frame-boundary latch: mode, rect_x, rect_y, rect_w and rect_h are captured into shadow registers when h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1. Mid-frame changes take effect on the next frame only; there is no tearing.
- Mode 0, colour bars:
  - BAR_W = H_ACTIVE/8.
  - Bar k covers x in [k*BAR_W, (k+1)*BAR_W); bar 7 also absorbs the remainder.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full scale = all ones on COLOR_W bits.
- Mode 1, checker: white if x[5]^y[5], else black (32x32 squares).
- Mode 2, rectangle:
  - Cyan (r=0, g=b=max) on the 1-pixel outline of the box from (rect_x, rect_y) to (rect_x+rect_w, rect_y+rect_h) inclusive; black elsewhere.
  - Additions use 13 bits, so no wrap; outline parts outside the active area are clipped.
  - rect_w==0 or rect_h==0 gives a single line segment.
- Mode 3, ramp: r=g=b=x[COLOR_W-1:0], wrapping every 2^COLOR_W pixels.
- frame_start is high for the single pixel where x==0 && y==0.
- Reset values:
  - Counters 0; shadow mode 0; shadow rect fields 0.
  - de=0, frame_start=0, rgb=0.
  - hs and vs at their inactive levels.
  - Pipeline registers cleared.
- Reset mid-frame clears everything immediately. After release, the first frame_start occurs 2 clocks after the counters first reach 0/0, i.e. after deassertion plus 2 clocks.

Decomposition:
- Package hdmi_pkg holds:
  - the pattern-mode encodings (MODE_BARS, MODE_CHECK, MODE_RECT, MODE_RAMP);
  - the bar colour table;
  - a function computing the totals from porch parameters.
- Sub-module hdmi_timing_gen contains the counters, raw de/hs/vs and x/y. It is reusable by later camera-overlay blocks.
- hdmi_pattern_gen instantiates hdmi_timing_gen and adds the frame-boundary latch, the pattern logic and the output pipeline.

Test Plan:
- Reset for 5 clocks, then release → de=0, hs=vs=1 (active-low default) and rgb=0 held during reset; first de rise 2 clocks after release.
- Free-run with defaults → hs period 800 clocks with 96 clocks low; de high for 640 consecutive clocks per line on 480 lines; vs low for 2 lines in a 525-line frame; frame_start once per 420000 clocks.
- mode=0 → pixel x=0 is FF/FF/FF; x=80 is FF/FF/00; x=639 is 00/00/00; 8 colour transitions per line.
- mode=2 with rect (270,190,100,80) → cyan at (270,190), (370,270) and (270,230); black at (271,191).
- mode switched from 0 to 1 at line 200 → rest of frame stays bars; next frame starts checker with (32,0) white.
- Override to H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1 → hs high for 3 of 24 clocks; reset asserted mid-line returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI/VGA pattern generator family:
// pattern-mode encodings, colour bar table and raster total helper.
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_RECT  = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  // One {r,g,b} full-scale enable triple per bar; bar 0 (white) sits in the low slot.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen_if.sv
// Configuration and video output bundle between the pattern generator
// (master) and the HDMI transmitter / register block (slave).
interface hdmi_pattern_gen_if #(
  parameter int COLOR_W = 8
);
  logic [1:0]         mode;
  logic [11:0]        rect_x;
  logic [11:0]        rect_y;
  logic [11:0]        rect_w;
  logic [11:0]        rect_h;
  logic               de;
  logic               hs;
  logic               vs;
  logic               frame_start;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;

  modport master (
    input  mode, rect_x, rect_y, rect_w, rect_h,
    output de, hs, vs, frame_start, vga_r, vga_g, vga_b
  );

  modport slave (
    output mode, rect_x, rect_y, rect_w, rect_h,
    input  de, hs, vs, frame_start, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster counters with raw (unregistered, polarity-free) timing and pixel
// coordinates; reusable by any block that needs to follow the video raster.
module hdmi_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_end
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vsync     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign x         = h_cnt;
  assign y         = v_cnt;
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Test pattern source for HDMI/VGA bring-up: raster timing plus four patterns,
// with configuration latched only at frame boundaries to avoid tearing.
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  hdmi_pattern_gen_if.master  vid
);

  localparam logic [11:0] BAR_DIV = 12'(H_ACTIVE / 8);

  logic        raw_de, raw_hs, raw_vs, frame_end;
  logic [11:0] raw_x, raw_y;

  hdmi_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .active    (raw_de),
    .hsync     (raw_hs),
    .vsync     (raw_vs),
    .x         (raw_x),
    .y         (raw_y),
    .frame_end (frame_end)
  );

  mode_e       mode_s;
  logic [11:0] rect_x_s, rect_y_s, rect_w_s, rect_h_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_s   <= MODE_BARS;
      rect_x_s <= '0;
      rect_y_s <= '0;
      rect_w_s <= '0;
      rect_h_s <= '0;
    end else if (frame_end) begin
      mode_s   <= mode_e'(vid.mode);
      rect_x_s <= vid.rect_x;
      rect_y_s <= vid.rect_y;
      rect_w_s <= vid.rect_w;
      rect_h_s <= vid.rect_h;
    end
  end

  logic        de1, hs1, vs1;
  logic [11:0] x1, y1;
  mode_e       mode1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      mode1 <= MODE_BARS;
    end else begin
      de1   <= raw_de;
      hs1   <= raw_hs;
      vs1   <= raw_vs;
      x1    <= raw_x;
      y1    <= raw_y;
      mode1 <= mode_s;
    end
  end

  logic [11:0]        bar_idx;
  logic [2:0]         bar_rgb;
  logic [12:0]        px, py, rx0, rx1, ry0, ry1;
  logic               on_outline;
  logic [COLOR_W-1:0] r_n, g_n, b_n;

  // Rectangle edges are compared in 13 bits so x+w / y+h never wrap back on screen.
  always_comb begin
    bar_idx    = x1 / BAR_DIV;
    bar_rgb    = BAR_TABLE[(bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0]];
    px         = {1'b0, x1};
    py         = {1'b0, y1};
    rx0        = {1'b0, rect_x_s};
    ry0        = {1'b0, rect_y_s};
    rx1        = rx0 + {1'b0, rect_w_s};
    ry1        = ry0 + {1'b0, rect_h_s};
    on_outline = (((px == rx0) || (px == rx1)) && (py >= ry0) && (py <= ry1)) ||
                 (((py == ry0) || (py == ry1)) && (px >= rx0) && (px <= rx1));
    r_n = '0;
    g_n = '0;
    b_n = '0;
    case (mode1)
      MODE_BARS: begin
        r_n = {COLOR_W{bar_rgb[2]}};
        g_n = {COLOR_W{bar_rgb[1]}};
        b_n = {COLOR_W{bar_rgb[0]}};
      end
      MODE_CHECK: begin
        r_n = {COLOR_W{x1[5] ^ y1[5]}};
        g_n = {COLOR_W{x1[5] ^ y1[5]}};
        b_n = {COLOR_W{x1[5] ^ y1[5]}};
      end
      MODE_RECT: begin
        g_n = {COLOR_W{on_outline}};
        b_n = {COLOR_W{on_outline}};
      end
      MODE_RAMP: begin
        r_n = x1[COLOR_W-1:0];
        g_n = x1[COLOR_W-1:0];
        b_n = x1[COLOR_W-1:0];
      end
    endcase
  end

  logic               de_q, hs_q, vs_q, fs_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      fs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      de_q <= de1;
      hs_q <= hs1 ? HS_POL : ~HS_POL;
      vs_q <= vs1 ? VS_POL : ~VS_POL;
      fs_q <= de1 && (x1 == 12'd0) && (y1 == 12'd0);
      r_q  <= de1 ? r_n : '0;
      g_q  <= de1 ? g_n : '0;
      b_q  <= de1 ? b_n : '0;
    end
  end

  assign vid.de          = de_q;
  assign vid.hs          = hs_q;
  assign vid.vs          = vs_q;
  assign vid.frame_start = fs_q;
  assign vid.vga_r       = r_q;
  assign vid.vga_g       = g_q;
  assign vid.vga_b       = b_q;

endmodule
